// File: rtl/kp_scanner.sv
// kp_scanner: 4x4 matrix keypad scanner. Rows are synchronized through two
// flops, and columns are walked one at a time. Presses and releases are both
// debounced, and a single key_valid strobe is emitted per accepted key.
// Optional feature: define KP_REPEAT_EN to emit auto-repeat strobes while a
// key stays held.
module kp_scanner #(
  parameter int unsigned SCAN_DIV     = 5000,
  parameter int unsigned DEBOUNCE_CNT = 100000,
  parameter int unsigned REPEAT_CYC   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] num,
  output logic       kphit,
  output logic       key_valid
);

  localparam int unsigned DW = $clog2(SCAN_DIV + 1);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);
`ifdef KP_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYC - 1);
`endif

  // The two-stage synchronizer needs the column to settle before its dwell
  // sample point. A repeat interval of 1 would merge strobes.
  if (SCAN_DIV < 3 || DEBOUNCE_CNT < 1 || REPEAT_CYC < 2) begin : g_bad_cfg
    $error("kp_scanner: SCAN_DIV must be >= 3, DEBOUNCE_CNT >= 1, REPEAT_CYC >= 2");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1, krs;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    num_q, num_d;
  logic          hit_q, hit_d;
  logic          kv_q, kv_d;
  logic          one_low;
  logic [1:0]    low_row;
`ifdef KP_REPEAT_EN
  logic [RW-1:0] rcnt_q, rcnt_d;
`endif

  function automatic logic [3:0] row_pattern(input logic [1:0] r);
    return ~(4'b1000 >> r);
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Bring the asynchronous row inputs into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      krs   <= '1;
    end else begin
      sync1 <= kpr;
      krs   <= sync1;
    end
  end

  // Detect exactly one active row and identify which one it is.
  always_comb begin
    one_low = 1'b1;
    low_row = 2'd0;
    case (krs)
      4'b0111: low_row = 2'd0;
      4'b1011: low_row = 2'd1;
      4'b1101: low_row = 2'd2;
      4'b1110: low_row = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Next-state logic: column walk, debounce counting and key event generation.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    hit_d   = hit_q;
    kv_d    = 1'b0;
`ifdef KP_REPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    case (state_q)
      SCAN: begin
        if (dcnt_q == DWELL_LAST) begin
          dcnt_d = '0;
          if (one_low) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (krs == row_pattern(row_q)) begin
          if (cnt_q == DB_LAST) begin
            state_d = HELD;
            num_d   = key_code(row_q, col_q);
            kv_d    = 1'b1;
            hit_d   = 1'b1;
            cnt_d   = '0;
`ifdef KP_REPEAT_EN
            rcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = SCAN;
          dcnt_d  = '0;
        end
      end
      HELD: begin
        hit_d = 1'b1;
        if (krs == 4'b1111) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
`ifdef KP_REPEAT_EN
          if (rcnt_q == RP_LAST) begin
            kv_d   = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
`endif
        end
      end
      RELEASE: begin
        // Repeat count is frozen here so a short release bounce resumes it.
        if (krs == 4'b1111) begin
          if (cnt_q == DB_LAST) begin
            state_d = SCAN;
            hit_d   = 1'b0;
            col_d   = col_q + 2'd1;
            dcnt_d  = '0;
            cnt_d   = '0;
`ifdef KP_REPEAT_EN
            rcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      hit_q   <= 1'b0;
      kv_q    <= 1'b0;
`ifdef KP_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      hit_q   <= hit_d;
      kv_q    <= kv_d;
`ifdef KP_REPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign kpc       = ~(4'b1000 >> col_q);
  assign num       = num_q;
  assign kphit     = hit_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_kp_scanner.sv
// tb_kp_scanner: randomized press/release bench for kp_scanner. A behavioural
// keypad model produces kpr from the driven column and the closed contacts.
`timescale 1ns/1ps
module tb_kp_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_CYC   = 32;
  localparam int TMO          = 200;
  localparam int LAT_MAX      = 2 + 5 * SCAN_DIV + DEBOUNCE_CNT + 2;

  logic       clk;
  logic       reset_n;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] num;
  logic       kphit;
  logic       key_valid;

  logic [3:0] contact [4];   // contact[r][c] = key at row r, column c closed
  logic [3:0] keymap  [4][4];
  logic [3:0] colseq  [4];

  int vectors;
  int miscompares;
  int kv_count;
  int cyc;
  logic kv_prev;
  int kv_cyc[$];
  logic [3:0] kv_num[$];

  kp_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_CYC  (REPEAT_CYC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .kpr      (kpr),
    .kpc      (kpc),
    .num      (num),
    .kphit    (kphit),
    .key_valid(key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Passive keypad: a closed key pulls its row low while its column is driven low.
  always_comb begin
    kpr = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (contact[r][c] && !kpc[3-c]) kpr[3-r] = 1'b0;
  end

  // Log every key event; a strobe must never last two cycles.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      kv_count++;
      kv_cyc.push_back(cyc);
      kv_num.push_back(num);
      vectors++;
      if (kv_prev) begin
        miscompares++;
        $display("FAIL key_valid_width: high on consecutive cycles at cycle %0d, required single-cycle", cyc);
      end
    end
    kv_prev = (key_valid === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required self-termination");
    $fatal(1, "watchdog");
  end

  task automatic clear_contacts();
    for (int r = 0; r < 4; r++) contact[r] = 4'b0000;
  endtask

  task automatic wait_kv(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < TMO) begin
      @(negedge clk);
      n++;
      if (key_valid === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL kv_timeout: key_valid not seen in %0d cycles, required a key event", TMO);
    end
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (kphit === 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n < DEBOUNCE_CNT || n > DEBOUNCE_CNT + 4) begin
      miscompares++;
      $display("FAIL release_time: kphit fell %0d cycles after release, required %0d..%0d",
               n, DEBOUNCE_CNT, DEBOUNCE_CNT + 4);
    end
  endtask

  task automatic wait_col1_onset(output bit ok);
    logic [3:0] prev;
    prev = kpc;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (kpc === 4'b1011 && prev !== 4'b1011) ok = 1'b1;
      prev = kpc;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL col1_timeout: kpc never switched to 1011, last %b", kpc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_contacts();
    repeat (3) @(negedge clk);
    vectors++;
    if (kpc !== 4'b0111) begin miscompares++; $display("FAIL reset_kpc: got %b, required 0111", kpc); end
    vectors++;
    if (num !== 4'h0) begin miscompares++; $display("FAIL reset_num: got %h, required 0", num); end
    vectors++;
    if (kphit !== 1'b0) begin miscompares++; $display("FAIL reset_kphit: got %b, required 0", kphit); end
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_kv: got %b, required 0", key_valid); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Two keys in one column must be ignored while the columns keep rotating.
  task automatic test_multi_key();
    logic [3:0] prev;
    int run, changes, base, idx;
    bit first;
    base = kv_count;
    contact[0][3] = 1'b1;
    contact[2][3] = 1'b1;
    prev = kpc;
    run = 0;
    changes = 0;
    first = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (kpc !== prev) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (colseq[k] === prev) idx = k;
        vectors++;
        if (kpc !== colseq[(idx + 1) % 4]) begin
          miscompares++;
          $display("FAIL col_order: kpc %b after %b, required %b", kpc, prev, colseq[(idx + 1) % 4]);
        end
        if (!first) begin
          vectors++;
          if (run != SCAN_DIV) begin
            miscompares++;
            $display("FAIL col_dwell: column %b held %0d cycles, required %0d", prev, run, SCAN_DIV);
          end
        end
        first = 1'b0;
        run = 1;
        changes++;
        prev = kpc;
      end else begin
        run++;
      end
    end
    vectors++;
    if (changes < 10) begin miscompares++; $display("FAIL multi_cycling: %0d column changes, required >= 10", changes); end
    vectors++;
    if (kv_count != base) begin miscompares++; $display("FAIL multi_kv: %0d key events, required 0", kv_count - base); end
    vectors++;
    if (kphit !== 1'b0) begin miscompares++; $display("FAIL multi_kphit: got %b, required 0", kphit); end
    clear_contacts();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_press(input int r, input int c, input int hold);
    int n, base;
    bit ok;
    logic [3:0] exp;
    exp = keymap[r][c];
    base = kv_count;
    contact[r][c] = 1'b1;
    wait_kv(n, ok);
    if (ok) begin
      vectors++;
      if (num !== exp) begin miscompares++; $display("FAIL press_num r%0d c%0d: got %h, required %h", r, c, num, exp); end
      vectors++;
      if (kphit !== 1'b1) begin miscompares++; $display("FAIL press_kphit r%0d c%0d: got %b, required 1", r, c, kphit); end
      vectors++;
      if (n < DEBOUNCE_CNT + 1 || n > LAT_MAX) begin
        miscompares++;
        $display("FAIL press_latency r%0d c%0d: %0d cycles, required %0d..%0d", r, c, n, DEBOUNCE_CNT + 1, LAT_MAX);
      end
    end
    repeat (hold) @(negedge clk);
    contact[r][c] = 1'b0;
    wait_release(n);
    vectors++;
    if (num !== exp) begin miscompares++; $display("FAIL num_hold r%0d c%0d: got %h, required %h", r, c, num, exp); end
    vectors++;
    if (kv_count - base != 1) begin
      miscompares++;
      $display("FAIL press_count r%0d c%0d: %0d key events, required 1", r, c, kv_count - base);
    end
  endtask

  task automatic test_random_press();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      test_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(2, 20)));
    end
  endtask

  // Key 0 (r3,c1) bounces once just after its column comes up.
  task automatic test_bounce();
    int n, base;
    bit ok;
    base = kv_count;
    wait_col1_onset(ok);
    contact[3][1] = 1'b1;
    n = 0;
    repeat (3) begin @(negedge clk); n++; end
    contact[3][1] = 1'b0;
    @(negedge clk); n++;
    contact[3][1] = 1'b1;
    ok = 1'b0;
    while (!ok && n < TMO) begin
      @(negedge clk);
      n++;
      if (key_valid === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok || n < 14 || n > 24) begin
      miscompares++;
      $display("FAIL bounce_latency: key_valid at %0d cycles after column onset, required 14..24", n);
    end
    vectors++;
    if (num !== 4'h0) begin miscompares++; $display("FAIL bounce_num: got %h, required 0", num); end
    repeat (5) @(negedge clk);
    contact[3][1] = 1'b0;
    wait_release(n);
    vectors++;
    if (kv_count - base != 1) begin miscompares++; $display("FAIL bounce_count: %0d key events, required 1", kv_count - base); end
  endtask

  // Key D briefly released for fewer cycles than the debounce: no new event.
  task automatic test_held_bounce();
    int n, base;
    bit ok, dropped;
    base = kv_count;
    contact[3][3] = 1'b1;
    wait_kv(n, ok);
    vectors++;
    if (num !== 4'hD) begin miscompares++; $display("FAIL held_num: got %h, required D", num); end
    repeat (5) @(negedge clk);
    contact[3][3] = 1'b0;
    repeat (4) @(negedge clk);
    contact[3][3] = 1'b1;
    dropped = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (kphit !== 1'b1) dropped = 1'b1;
    end
    vectors++;
    if (dropped) begin miscompares++; $display("FAIL held_kphit: kphit dropped during short release, required 1"); end
    vectors++;
    if (kv_count - base != 1) begin miscompares++; $display("FAIL held_count: %0d key events, required 1", kv_count - base); end
    contact[3][3] = 1'b0;
    wait_release(n);
  endtask

  // Reset in the middle of debouncing key 5, key kept held throughout.
  task automatic test_reset_mid();
    int n, base;
    bit ok;
    base = kv_count;
    wait_col1_onset(ok);
    contact[1][1] = 1'b1;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (kpc !== 4'b0111) begin miscompares++; $display("FAIL areset_kpc: got %b, required 0111", kpc); end
    vectors++;
    if (num !== 4'h0) begin miscompares++; $display("FAIL areset_num: got %h, required 0", num); end
    vectors++;
    if (kphit !== 1'b0 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_flags: kphit %b key_valid %b, required 0 0", kphit, key_valid);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (kv_count != base) begin miscompares++; $display("FAIL areset_abort: %0d key events, required 0", kv_count - base); end
    reset_n = 1'b1;
    wait_kv(n, ok);
    vectors++;
    if (num !== 4'h5) begin miscompares++; $display("FAIL rescan_num: got %h, required 5", num); end
    vectors++;
    if (n < SCAN_DIV + DEBOUNCE_CNT + 2) begin
      miscompares++;
      $display("FAIL rescan_latency: %0d cycles after reset, required >= %0d", n, SCAN_DIV + DEBOUNCE_CNT + 2);
    end
    repeat (3) @(negedge clk);
    contact[1][1] = 1'b0;
    wait_release(n);
    vectors++;
    if (kv_count - base != 1) begin miscompares++; $display("FAIL rescan_count: %0d key events, required 1", kv_count - base); end
  endtask

  // Key A held about 100 cycles beyond the first event.
  task automatic test_repeat();
    int n, exp_events;
    bit ok;
    kv_cyc.delete();
    kv_num.delete();
    contact[0][3] = 1'b1;
    wait_kv(n, ok);
    repeat (100) @(negedge clk);
    contact[0][3] = 1'b0;
    wait_release(n);
`ifdef KP_REPEAT_EN
    exp_events = 4;
`else
    exp_events = 1;
`endif
    vectors++;
    if (kv_cyc.size() != exp_events) begin
      miscompares++;
      $display("FAIL repeat_count: %0d key events, required %0d", kv_cyc.size(), exp_events);
    end
    for (int i = 0; i < kv_cyc.size() && i < exp_events; i++) begin
      vectors++;
      if (kv_cyc[i] - kv_cyc[0] != i * REPEAT_CYC || kv_num[i] !== 4'hA) begin
        miscompares++;
        $display("FAIL repeat_event %0d: offset %0d num %h, required offset %0d num A",
                 i, kv_cyc[i] - kv_cyc[0], kv_num[i], i * REPEAT_CYC);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    kv_count = 0;
    kv_prev = 1'b0;
    cyc = 0;
    keymap = '{'{4'h1, 4'h2, 4'h3, 4'hA},
               '{4'h4, 4'h5, 4'h6, 4'hB},
               '{4'h7, 4'h8, 4'h9, 4'hC},
               '{4'hE, 4'h0, 4'hF, 4'hD}};
    colseq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    clear_contacts();
    reset_n = 1'b0;
    test_reset();
    test_multi_key();
    test_press(1, 2, 20);
    test_random_press();
    test_bounce();
    test_held_bounce();
    test_reset_mid();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kp_scanner.md
KP_SCANNER -- requirements
Module: kp_scanner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SCAN_DIV  5000  clk cycles each column is driven before kpr is sampled
  DEBOUNCE_CNT  100000  consecutive stable clk cycles required for press and for release
  REPEAT_CYC  25000000  auto-repeat interval in clk cycles (KP_REPEAT_EN only)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  system clock, rising edge
  reset_n  input  1  asynchronous active-low reset
  kpr  input  4  keypad rows, active-low, externally pulled up
  kpc  output  4  keypad column drive, one bit low at a time
  num  output  4  code of last accepted key
  kphit  output  1  high while a debounced key is held
  key_valid  output  1  one-cycle strobe per accepted key event

Function
REQ-003 kpr SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (krs).
REQ-004 Column index c (0..3) SHALL drive kpc bit (3-c) low and all other bits high.
REQ-005 Row index r (0..3) SHALL be the low bit of krs, with bit (3-r) low meaning row r.
REQ-006 Key map, listed as row r: keys for c=0..3, SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
REQ-007 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-008 SCAN:
  - hold c for SCAN_DIV cycles, then sample krs.
  - exactly one bit low: latch r and c, clear counter, go to DEBOUNCE.
  - otherwise (none or several low): advance c by 1, wrapping 3 to 0, restart dwell.
REQ-009 DEBOUNCE:
  - c frozen; counter increments while krs equals the latched pattern.
  - any mismatch: return to SCAN at the same c with dwell restarted.
  - counter reaching DEBOUNCE_CNT: go to HELD.
REQ-010 On DEBOUNCE to HELD, in the same cycle: num SHALL load the mapped code, key_valid SHALL pulse high for exactly 1 cycle, and kphit SHALL go to 1.
REQ-011 HELD: c frozen, kphit=1; krs==4'b1111 SHALL move to RELEASE with counter cleared; any other pattern SHALL stay in HELD.
REQ-012 RELEASE:
  - counter increments while krs==4'b1111.
  - any low bit: return to HELD, no new key_valid.
  - counter reaching DEBOUNCE_CNT: go to SCAN, kphit=0, advance c.
REQ-013 num SHALL hold its value until the next accepted key; key_valid SHALL never be high for two consecutive cycles.
REQ-014 Counters SHALL be sized from the parameters, with no overflow or wrap at any configured value.
REQ-015 Latency, in clk cycles, SHALL be: press stable at kpr pins to key_valid = 2 (sync) + remaining dwell + DEBOUNCE_CNT.

Reset
REQ-016 reset_n low SHALL immediately (asynchronously) set:
  - state=SCAN, c=0, kpc=4'b0111.
  - num=4'h0, kphit=0, key_valid=0.
  - counters=0, synchronizer flops=4'b1111.
REQ-017 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL abort the event without a key_valid pulse; after reset_n rises, a key still held SHALL be re-detected through a full SCAN and DEBOUNCE.

Configuration
REQ-018 With macro KP_REPEAT_EN defined:
  - in HELD, a repeat counter SHALL pulse key_valid (num unchanged) every REPEAT_CYC cycles after entering HELD.
  - the repeat counter SHALL clear on leaving HELD and SHALL keep its count on a RELEASE to HELD bounce.
REQ-019 With KP_REPEAT_EN undefined, the repeat counter and the REPEAT_CYC logic SHALL be absent, and a held key SHALL produce exactly one key_valid.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CYC=32)
REQ-020 Press r1/c2 held 40 cycles -> one key_valid, num=4'h6, kphit high until 8 cycles after release.
REQ-021 Press r3/c1 with bounce (low 3 cycles, high 1, then stable) -> DEBOUNCE aborts once, then key_valid with num=4'h0; exactly one pulse.
REQ-022 Rows r0 and r2 both low on c=3 -> no key_valid, kpc keeps cycling 0111,1011,1101,1110,0111.
REQ-023 Key D held, then krs=1111 for 4 cycles, then low again -> stays HELD, no second key_valid, kphit stays 1.
REQ-024 reset_n pulsed low during DEBOUNCE of key 5 -> kpc=0111, num=0 at once, no key_valid; key still held -> key_valid with num=4'h5 after full re-scan.
REQ-025 KP_REPEAT_EN defined, key A held 100 cycles after HELD -> key_valid at HELD entry and at +32, +64 and +96, each with num=4'hA.
